// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Define ADDER_ARBITER_STATS_EN to add a saturating txn_count of completed responses.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_valid,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry
`ifdef ADDER_ARBITER_STATS_EN
    ,
    output logic [15:0]              txn_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             accept;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        logic [IDW-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_found && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_found) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        add_valid = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  if (accept) req_ready[grant_idx] = 1'b1;
            S_ISSUE: add_valid = 1'b1;
            S_WAIT:  ;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= IDW'(NUM_REQ - 1);
            id_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            if (accept) begin
                last_q <= grant_idx;
                id_q   <= grant_idx;
                op_a_q <= sel_a;
                op_b_q <= sel_b;
            end
            if (state_q == S_WAIT) begin
                sum_q   <= add_sum;
                carry_q <= add_carry;
            end
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;

`ifdef ADDER_ARBITER_STATS_EN
    logic [15:0] txn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q <= '0;
        end else if (state_q == S_RESP && rsp_ready && txn_q != 16'hFFFF) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    assign txn_count = txn_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random stimulus for adder_arbiter against a
// transaction-level model; a registered adder is emulated in the bench.
module tb_adder_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [W-1:0]   add_a, add_b;
    logic           add_valid;
    logic [W-1:0]   add_sum = '0;
    logic           add_carry = 1'b0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
`ifdef ADDER_ARBITER_STATS_EN
    logic [15:0]    txn_count;
`endif

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_valid (add_valid),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
`ifdef ADDER_ARBITER_STATS_EN
        ,
        .txn_count (txn_count)
`endif
    );

    always #5 clk = ~clk;

    // Shared adder: result appears one cycle after add_valid.
    always @(posedge clk) begin
        if (add_valid) {add_carry, add_sum} <= 9'(add_a) + 9'(add_b);
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: cycles since acceptance (0 = free), last winner, last operands.
    int         busy = 0;
    int         last = N - 1;
    logic [W-1:0] m_a = '0, m_b = '0;
    int         m_id = 0;
    logic [W:0] m_res = '0;
    bit         just_rst = 1'b0;
    int         txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int lg);
        for (int k = 1; k <= N; k++) begin
            if (v[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] v,
                        input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic rr);
        int w;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        w = pick(v, last);
        exp_rdy = '0;
        if (busy == 0 && !r && w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("add_valid", 32'(add_valid), 32'(busy == 1));
        check("add_a", 32'(add_a), 32'(m_a));
        check("add_b", 32'(add_b), 32'(m_b));
        check("rsp_valid", 32'(rsp_valid), 32'(busy == 3));
        if (busy == 3 || just_rst) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_sum", 32'(rsp_sum), 32'(m_res[W-1:0]));
            check("rsp_carry", 32'(rsp_carry), 32'(m_res[W]));
        end
`ifdef ADDER_ARBITER_STATS_EN
        check("txn_count", 32'(txn_count), 32'(txn));
`endif
        just_rst = r;
        if (r) begin
            busy  = 0;
            last  = N - 1;
            m_a   = '0;
            m_b   = '0;
            m_id  = 0;
            m_res = '0;
            txn   = 0;
        end else if (busy == 0) begin
            if (w >= 0) begin
                busy  = 1;
                last  = w;
                m_id  = w;
                m_a   = W'(a >> (w * W));
                m_b   = W'(b >> (w * W));
                m_res = 9'(m_a) + 9'(m_b);
            end
        end else if (busy < 3) begin
            busy++;
        end else if (rr) begin
            busy = 0;
            if (txn < 65535) txn++;
        end
    endtask

    function automatic logic [N*W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    initial begin
        step(1'b1, '0, '0, '0, 1'b1);
        step(1'b1, '0, '0, '0, 1'b1);

        // Single request from requester 0: 12 + 34.
        step(1'b0, 4'b0001, 32'h0000_0012, 32'h0000_0034, 1'b1);
        repeat (3) step(1'b0, '0, rnd(), rnd(), 1'b1);
        check("sum_46", 32'(rsp_sum), 32'h46);
        step(1'b0, '0, rnd(), rnd(), 1'b1);

        // All requesters valid: rotating grants.
        repeat (24) step(1'b0, 4'b1111, rnd(), rnd(), 1'b1);

        // Requester 2 overflow: FF + 02.
        step(1'b1, '0, '0, '0, 1'b1);
        step(1'b0, 4'b0100, 32'h00FF_0000, 32'h0002_0000, 1'b1);
        repeat (3) step(1'b0, '0, rnd(), rnd(), 1'b1);
        check("carry_ff02", 32'({rsp_carry, rsp_sum}), 32'h101);
        step(1'b0, '0, rnd(), rnd(), 1'b1);

        // Back-pressure in RESP with requests pending.
        step(1'b0, 4'b1111, rnd(), rnd(), 1'b0);
        repeat (7) step(1'b0, 4'b1111, rnd(), rnd(), 1'b0);
        step(1'b0, 4'b1111, rnd(), rnd(), 1'b1);
        repeat (4) step(1'b0, 4'b1111, rnd(), rnd(), 1'b1);

        // Reset during WAIT aborts; next grant goes to requester 0.
        step(1'b1, '0, '0, '0, 1'b1);
        step(1'b0, 4'b0010, rnd(), rnd(), 1'b1);
        step(1'b0, '0, rnd(), rnd(), 1'b1);
        step(1'b1, 4'b1111, rnd(), rnd(), 1'b1);
        step(1'b0, 4'b1111, rnd(), rnd(), 1'b1);
        repeat (4) step(1'b0, 4'b1111, rnd(), rnd(), 1'b1);

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 63) == 0, N'($urandom), rnd(), rnd(),
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
